// File: rtl/apple_if.sv
// Signal bundle between the apple manager, the random position generator,
// the VGA draw logic and the game control logic.
interface apple_if #(
  parameter int SCORE_W = 8
);
  logic               tick;
  logic [9:0]         head_X;
  logic [8:0]         head_Y;
  logic [9:0]         rand_X;
  logic [8:0]         rand_Y;
  logic               update;
  logic [9:0]         apple_X;
  logic [8:0]         apple_Y;
  logic               apple_valid;
  logic               eaten;
  logic [SCORE_W-1:0] score;

  modport master (
    input  tick, head_X, head_Y, rand_X, rand_Y,
    output update, apple_X, apple_Y, apple_valid, eaten, score
  );

  modport slave (
    output tick, head_X, head_Y, rand_X, rand_Y,
    input  update, apple_X, apple_Y, apple_valid, eaten, score
  );
endinterface

// File: rtl/apple_manager.sv
// Holds the live apple, detects the snake head eating it, requests a fresh
// random position from the generator (retrying on head overlap) and keeps score.
module apple_manager #(
  parameter int APPLE_SIZE = 10,
  parameter int INIT_X     = 70,
  parameter int INIT_Y     = 90,
  parameter int SCORE_W    = 8,
  parameter int MAX_RETRY  = 3
) (
  input logic    VGA_clk,
  input logic    reset,
  apple_if.master bus
);

  localparam logic [2:0] ACTIVE  = 3'd0;
  localparam logic [2:0] UPD_HI1 = 3'd1;
  localparam logic [2:0] UPD_HI2 = 3'd2;
  localparam logic [2:0] SETTLE  = 3'd3;
  localparam logic [2:0] SAMPLE  = 3'd4;

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]      RETRY_LIMIT = RW'(MAX_RETRY);
  localparam logic [10:0]        SPAN_X      = 11'(APPLE_SIZE - 1);
  localparam logic [9:0]         SPAN_Y      = 10'(APPLE_SIZE - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;

  logic [2:0]    state;
  logic [RW-1:0] retry_cnt;

  // Bounds are widened one bit so an apple near the screen edge never wraps.
  function automatic logic overlap(input logic [9:0] ax, input logic [8:0] ay,
                                   input logic [9:0] hx, input logic [8:0] hy);
    logic [10:0] x_end;
    logic [9:0]  y_end;
    x_end = {1'b0, ax} + SPAN_X;
    y_end = {1'b0, ay} + SPAN_Y;
    return (hx >= ax) && ({1'b0, hx} <= x_end) &&
           (hy >= ay) && ({1'b0, hy} <= y_end);
  endfunction

  // NOTE: state is written only with non-blocking assignments so every read
  // in this block sees the value from before the clock edge.
  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      state           <= ACTIVE;
      retry_cnt       <= '0;
      bus.apple_X     <= 10'(INIT_X);
      bus.apple_Y     <= 9'(INIT_Y);
      bus.apple_valid <= 1'b1;
      bus.update      <= 1'b0;
      bus.eaten       <= 1'b0;
      bus.score       <= '0;
    end else begin
      // NOTE: default-low here makes eaten a single-cycle pulse.
      bus.eaten <= 1'b0;
      case (state)
        ACTIVE: begin
          if (bus.tick && overlap(bus.apple_X, bus.apple_Y, bus.head_X, bus.head_Y)) begin
            state           <= UPD_HI1;
            bus.eaten       <= 1'b1;
            bus.apple_valid <= 1'b0;
            bus.update      <= 1'b1;
            retry_cnt       <= '0;
            if (bus.score != SCORE_MAX) bus.score <= bus.score + 1'b1;
          end
        end
        UPD_HI1: state <= UPD_HI2;
        UPD_HI2: begin
          bus.update <= 1'b0;
          state      <= SETTLE;
        end
        SETTLE: state <= SAMPLE;
        SAMPLE: begin
          // The generator output is the candidate; a retry leaves eaten/score alone.
          if (overlap(bus.rand_X, bus.rand_Y, bus.head_X, bus.head_Y) &&
              (retry_cnt < RETRY_LIMIT)) begin
            retry_cnt  <= retry_cnt + 1'b1;
            bus.update <= 1'b1;
            state      <= UPD_HI1;
          end else begin
            bus.apple_X     <= bus.rand_X;
            bus.apple_Y     <= bus.rand_Y;
            bus.apple_valid <= 1'b1;
            state           <= ACTIVE;
          end
        end
        default: state <= ACTIVE;
      endcase
    end
  end

endmodule

// File: tb/tb_apple_manager.sv
// Self-checking bench for apple_manager: boundary vector table, directed
// multi-cycle sequences and randomized traffic against a transaction-level model.
module tb_apple_manager;

  logic       VGA_clk = 1'b0;
  logic       reset   = 1'b1;
  logic       tick    = 1'b0;
  logic [9:0] head_X  = '0;
  logic [8:0] head_Y  = '0;
  logic [9:0] rand_X  = '0;
  logic [8:0] rand_Y  = '0;

  always #5 VGA_clk = ~VGA_clk;

  apple_if #(.SCORE_W(8)) bus8 ();
  apple_if #(.SCORE_W(2)) bus2 ();

  assign bus8.tick = tick;  assign bus8.head_X = head_X;  assign bus8.head_Y = head_Y;
  assign bus8.rand_X = rand_X;  assign bus8.rand_Y = rand_Y;
  assign bus2.tick = tick;  assign bus2.head_X = head_X;  assign bus2.head_Y = head_Y;
  assign bus2.rand_X = rand_X;  assign bus2.rand_Y = rand_Y;

  apple_manager #(.SCORE_W(8)) dut  (.VGA_clk(VGA_clk), .reset(reset), .bus(bus8));
  apple_manager #(.SCORE_W(2)) dut2 (.VGA_clk(VGA_clk), .reset(reset), .bus(bus2));

  int n_checks = 0;
  int n_pass   = 0;
  int eat_cnt  = 0;

  // Reference model: apple position plus "busy" transaction with a phase
  // (1..4 cycles into the current generator request) and retries used.
  int m_ax, m_ay, m_count, m_p, m_tries;
  bit m_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic bit ovl(input int ax, input int ay, input int hx, input int hy);
    return (hx >= ax) && (hx < ax + 10) && (hy >= ay) && (hy < ay + 10);
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_ax = 70; m_ay = 90; m_count = 0; m_busy = 0; m_p = 0; m_tries = 0;
  endtask

  task automatic model_step();
    if (!m_busy) begin
      if (tick && ovl(m_ax, m_ay, int'(head_X), int'(head_Y))) begin
        m_busy = 1; m_p = 1; m_tries = 0; m_count++;
      end
    end else if (m_p < 4) begin
      m_p++;
    end else if (ovl(int'(rand_X), int'(rand_Y), int'(head_X), int'(head_Y)) && m_tries < 3) begin
      m_tries++; m_p = 1;
    end else begin
      m_ax = int'(rand_X); m_ay = int'(rand_Y); m_busy = 0;
    end
  endtask

  task automatic compare_all();
    check("update",  32'(bus8.update),      32'(m_busy && m_p <= 2));
    check("eaten",   32'(bus8.eaten),       32'(m_busy && m_p == 1 && m_tries == 0));
    check("valid",   32'(bus8.apple_valid), 32'(!m_busy));
    check("apple_X", 32'(bus8.apple_X),     32'(m_ax));
    check("apple_Y", 32'(bus8.apple_Y),     32'(m_ay));
    check("score8",  32'(bus8.score),       32'(sat(m_count, 8)));
    check("score2",  32'(bus2.score),       32'(sat(m_count, 2)));
    check("eaten2",  32'(bus2.eaten),       32'(bus8.eaten));
  endtask

  task automatic step();
    model_step();
    @(posedge VGA_clk); #1;
    if (bus8.eaten) eat_cnt++;
    compare_all();
  endtask

  task automatic set_in(input int hx, input int hy, input int rx, input int ry, input bit t);
    head_X = 10'(hx); head_Y = 9'(hy); rand_X = 10'(rx); rand_Y = 9'(ry); tick = t;
  endtask

  typedef struct {
    int hx;
    int hy;
    bit hit;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int s0, e0, lat, rises;
    bit prev_upd;
    int exp_sat[5];

    vecs[0] = '{0, 0, 1'b0};    vecs[1] = '{79, 99, 1'b1};
    vecs[2] = '{80, 90, 1'b0};  vecs[3] = '{70, 100, 1'b0};
    vecs[4] = '{70, 90, 1'b1};  vecs[5] = '{69, 95, 1'b0};
    vecs[6] = '{75, 89, 1'b0};  vecs[7] = '{79, 90, 1'b1};
    exp_sat = '{1, 2, 3, 3, 3};

    // Reset state
    model_reset();
    repeat (2) @(posedge VGA_clk);
    #1 reset = 1'b0;
    compare_all();

    // Hit-window boundary table; every hit respawns the apple at (70,90)
    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].hx, vecs[i].hy, 70, 90, 1'b1);
      step();
      check("vec_eaten", 32'(bus8.eaten), 32'(vecs[i].hit));
      set_in(0, 0, 70, 90, 1'b0);
      if (vecs[i].hit) repeat (4) step();
      check("vec_valid", 32'(bus8.apple_valid), 32'd1);
    end

    // Basic eat: pulse timing and new position at T+5
    s0 = int'(bus8.score);
    set_in(79, 99, 130, 110, 1'b1);
    step();
    check("t1_eaten", 32'(bus8.eaten), 32'd1);
    check("t1_update", 32'(bus8.update), 32'd1);
    set_in(0, 0, 130, 110, 1'b0);
    step();
    check("t2_eaten", 32'(bus8.eaten), 32'd0);
    check("t2_update", 32'(bus8.update), 32'd1);
    step();
    check("t3_update", 32'(bus8.update), 32'd0);
    step();
    check("t4_valid", 32'(bus8.apple_valid), 32'd0);
    step();
    check("t5_valid", 32'(bus8.apple_valid), 32'd1);
    check("t5_apple_X", 32'(bus8.apple_X), 32'd130);
    check("t5_apple_Y", 32'(bus8.apple_Y), 32'd110);
    check("t5_score", 32'(bus8.score), 32'(s0 + 1));

    // Retry: candidate keeps landing on the head, fourth sample is accepted
    s0 = int'(bus8.score);
    e0 = eat_cnt;
    set_in(130, 110, 200, 200, 1'b1);
    step();
    set_in(205, 205, 200, 200, 1'b0);
    lat = 0; rises = 1; prev_upd = bus8.update;
    while (!bus8.apple_valid && lat < 40) begin
      step();
      lat++;
      if (bus8.update && !prev_upd) rises++;
      prev_upd = bus8.update;
    end
    check("retry_latency", 32'(lat), 32'd16);
    check("retry_update_pulses", 32'(rises), 32'd4);
    check("retry_eaten", 32'(eat_cnt - e0), 32'd1);
    check("retry_score", 32'(bus8.score), 32'(s0 + 1));
    check("retry_apple_X", 32'(bus8.apple_X), 32'd200);
    check("retry_apple_Y", 32'(bus8.apple_Y), 32'd200);

    // Ticks while busy are ignored
    s0 = int'(bus8.score);
    e0 = eat_cnt;
    set_in(200, 200, 300, 300, 1'b1);
    repeat (6) step();
    tick = 1'b0;
    check("busy_tick_eaten", 32'(eat_cnt - e0), 32'd1);
    check("busy_tick_score", 32'(bus8.score), 32'(s0 + 1));

    // 2-bit score saturation after a fresh reset
    #1 reset = 1'b1;
    model_reset();
    #1 reset = 1'b0;
    e0 = eat_cnt;
    for (int i = 0; i < 5; i++) begin
      set_in(70, 90, 70, 90, 1'b1);
      step();
      set_in(0, 0, 70, 90, 1'b0);
      repeat (4) step();
      check("sat_score2", 32'(bus2.score), 32'(exp_sat[i]));
    end
    check("sat_eaten_pulses", 32'(eat_cnt - e0), 32'd5);

    // Reset during UPD_HI2 clears update immediately
    set_in(72, 92, 300, 300, 1'b1);
    step();
    set_in(0, 0, 300, 300, 1'b0);
    step();
    check("pre_reset_update", 32'(bus8.update), 32'd1);
    #1 reset = 1'b1;
    #1;
    model_reset();
    check("rst_update", 32'(bus8.update), 32'd0);
    check("rst_apple_X", 32'(bus8.apple_X), 32'd70);
    check("rst_apple_Y", 32'(bus8.apple_Y), 32'd90);
    check("rst_valid", 32'(bus8.apple_valid), 32'd1);
    check("rst_score8", 32'(bus8.score), 32'd0);
    check("rst_score2", 32'(bus2.score), 32'd0);
    #1 reset = 1'b0;

    // Randomized traffic biased toward the apple and toward head-overlapping candidates
    for (int c = 0; c < 3000; c++) begin
      int hx, hy, rx, ry;
      if ($urandom_range(1) == 0) begin
        hx = m_ax + int'($urandom_range(13)) - 2;
        hy = m_ay + int'($urandom_range(13)) - 2;
      end else begin
        hx = int'($urandom_range(1023));
        hy = int'($urandom_range(511));
      end
      if (hx < 0) hx = 0;
      if (hy < 0) hy = 0;
      hx = hx & 1023;
      hy = hy & 511;
      if ($urandom_range(2) == 0) begin
        rx = (hx - int'($urandom_range(9))) & 1023;
        ry = (hy - int'($urandom_range(9))) & 511;
      end else begin
        rx = int'($urandom_range(1023));
        ry = int'($urandom_range(511));
      end
      set_in(hx, hy, rx, ry, $urandom_range(3) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
